gfx_cmd_queue: RTL

Upstream feeder for the graphics connector and core.
- Buffers 24-bit graphics commands ({cmd[7:0], data[15:0]}) written by the CPU side.
- Drains them onto the 32-bit device bus as {DEVADDR, 6'b0, cmd, data}, with a guaranteed minimum idle gap between words.
- Supports a reserved barrier command that stalls draining until the next vertical-blank pulse, so texture, palette and sprite updates land outside active video.

---
 rtl/gfx_pkg.sv | 20 ++
 rtl/gfx_cmd_fifo.sv | 53 +++++
 rtl/gfx_cmd_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared widths, state encoding and bus-word packing for the graphics command queue.
package gfx_pkg;
  localparam int CMD_W  = 8;
  localparam int DATA_W = 16;
  localparam int BUS_W  = 32;
  localparam int ENT_W  = CMD_W + DATA_W;

  localparam logic [CMD_W-1:0] WAIT_CMD_DEF = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT_VB
  } state_t;

  function automatic logic [BUS_W-1:0] mk_word(input logic [1:0] dev, input logic [ENT_W-1:0] ent);
    return {dev, 6'b0, ent};
  endfunction
endpackage

// File: rtl/gfx_cmd_fifo.sv
// Synchronous command FIFO: push/pop take effect on the edge, head is a combinational read of the
// oldest entry; a push while full is dropped (no pop-makes-room bypass), flush clears everything.
module gfx_cmd_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ENT_W-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [ENT_W-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_q];
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/gfx_cmd_queue.sv
// Drains queued graphics commands onto the device bus: push-to-bus latency 2 cycles, one word per GAP+1 cycles.
// No upstream backpressure (full drops + sticky ovf); hold blocks new pops, barrier command waits for vblank.
module gfx_cmd_queue
  import gfx_pkg::*;
#(
  parameter int               DEPTH    = 16,
  parameter logic [1:0]       DEVADDR  = 2'd2,
  parameter int               GAP      = 1,
  parameter logic [CMD_W-1:0] WAIT_CMD = WAIT_CMD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [CMD_W-1:0]       wr_cmd,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   flush,
  input  logic                   hold,
  input  logic                   vblank,
  output logic [BUS_W-1:0]       out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   ovf
);
  localparam logic [3:0] GAP_L = 4'(GAP);

  state_t           state_q;
  logic [BUS_W-1:0] out_q;
  logic [ENT_W-1:0] stage_q;
  logic [3:0]       gap_q;
  logic             ovf_q;

  logic [ENT_W-1:0] head;
  logic             fifo_full, fifo_empty;
  logic             pop_slot, pop;

  gfx_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .push_dat ({wr_cmd, wr_data}),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (level)
  );

  // The last gap cycle doubles as the pop slot so the next word lands right after the gap.
  always_comb begin
    pop_slot = (state_q == S_IDLE)
            || (state_q == S_GAP && gap_q == 4'd1)
            || (state_q == S_ISSUE && GAP == 0);
    pop      = pop_slot && !fifo_empty && !hold && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      stage_q <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      stage_q <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en && fifo_full) ovf_q <= 1'b1;
      case (state_q)
        S_IDLE: out_q <= '0;
        S_ISSUE: begin
          out_q   <= mk_word(DEVADDR, stage_q);
          gap_q   <= GAP_L;
          state_q <= (GAP == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          out_q <= '0;
          if (gap_q == 4'd1) state_q <= S_IDLE;
          else               gap_q   <= gap_q - 4'd1;
        end
        S_WAIT_VB: begin
          out_q <= '0;
          if (vblank) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (pop) begin
        stage_q <= head;
        state_q <= (head[ENT_W-1:DATA_W] == WAIT_CMD) ? S_WAIT_VB : S_ISSUE;
      end
    end
  end

  assign out   = out_q;
  assign full  = fifo_full;
  assign empty = fifo_empty;
  assign busy  = !fifo_empty || (state_q != S_IDLE);
  assign ovf   = ovf_q;
endmodule
